// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one byte-wide, single-port synchronous RAM between the instruction
//   fetch port (I, word reads only) and the load/store port (D, byte/half/word).
//   Each access is split into big-endian byte cycles. The result comes back
//   with a one-cycle done pulse on the port that was granted.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   i_req/i_addr                fetch request (held until i_done)
//   i_rdata/i_done/i_err        fetched word, completion pulse, misaligned flag
//   d_req/d_we/d_size/d_signed  load/store request (held until d_done)
//   d_addr/d_wdata              byte address, right-justified store data
//   d_rdata/d_done/d_err        load result, completion pulse, error flag
//   mem_addr/mem_we/mem_wdata   byte RAM command
//   mem_rdata                   byte RAM read data (address of previous cycle)
//   busy                        high in any non-IDLE state
//
// state | meaning
// IDLE  | arbitrate between I and D, latch the winning request
// ISSUE | drive one byte cycle per clock, cnt = 0..N-1
// CAPT  | capture the final read byte of a load
// DONE  | done pulse on the granted port, then back to IDLE
module mem_port_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_done,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_signed,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_CAPT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // index of the last byte of an access of the given size
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    endfunction

    // byte k of the big-endian slice: byte 0 is the most significant byte
    function automatic logic [7:0] store_byte(input logic [31:0] wd,
                                              input logic [1:0]  size,
                                              input logic [1:0]  k);
        logic [1:0] pos;
        pos = last_idx(size) - k;
        case (pos)
            2'd0:    store_byte = wd[7:0];
            2'd1:    store_byte = wd[15:8];
            2'd2:    store_byte = wd[23:16];
            default: store_byte = wd[31:24];
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] a,
                                           input logic [1:0]  size,
                                           input logic        sgn);
        case (size)
            2'b00:   extend = {{24{sgn & a[7]}}, a[7:0]};
            2'b01:   extend = {{16{sgn & a[15]}}, a[15:0]};
            default: extend = a;
        endcase
    endfunction

    function automatic logic access_err(input logic [1:0] size,
                                        input logic [1:0] a_lo);
        case (size)
            2'b00:   access_err = 1'b0;
            2'b01:   access_err = a_lo[0];
            2'b10:   access_err = (a_lo != 2'b00);
            default: access_err = 1'b1;
        endcase
    endfunction

    logic [1:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              port_q, port_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              signed_q, signed_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       acc_q, acc_d;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [31:0]       i_rdata_q, i_rdata_d;
    logic              i_done_q, i_done_d;
    logic              i_err_q, i_err_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              d_done_q, d_done_d;
    logic              d_err_q, d_err_d;
    logic              busy_q, busy_d;

    logic              gnt_d_port;
    logic [ADDR_W-1:0] sel_addr;
    logic [1:0]        sel_size;
    logic              sel_we;
    logic              sel_err;
    logic [1:0]        cnt_nxt;
    logic [31:0]       acc_full;

    always_comb begin
        // D wins a conflict unless it had the previous grant
        gnt_d_port = d_req && (!i_req || (last_grant_q == PORT_I));
        sel_addr   = gnt_d_port ? d_addr : i_addr;
        sel_size   = gnt_d_port ? d_size : 2'b10;
        sel_we     = gnt_d_port & d_we;
        sel_err    = access_err(sel_size, sel_addr[1:0]);
        cnt_nxt    = cnt_q + 2'd1;
        acc_full   = {acc_q[23:0], mem_rdata};

        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        addr_d       = addr_q;
        size_d       = size_q;
        we_d         = we_q;
        signed_d     = signed_q;
        wdata_d      = wdata_q;
        acc_d        = acc_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        i_done_d     = 1'b0;
        i_err_d      = 1'b0;
        d_rdata_d    = d_rdata_q;
        d_done_d     = 1'b0;
        d_err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_req || d_req) begin
                    port_d       = gnt_d_port;
                    last_grant_d = gnt_d_port;
                    addr_d       = sel_addr;
                    size_d       = sel_size;
                    we_d         = sel_we;
                    signed_d     = d_signed;
                    wdata_d      = d_wdata;
                    acc_d        = 32'd0;
                    cnt_d        = 2'd0;
                    if (sel_err) begin
                        state_d = S_DONE;
                        if (gnt_d_port) begin
                            d_done_d  = 1'b1;
                            d_err_d   = 1'b1;
                            d_rdata_d = 32'd0;
                        end else begin
                            i_done_d  = 1'b1;
                            i_err_d   = 1'b1;
                            i_rdata_d = 32'd0;
                        end
                    end else begin
                        state_d     = S_ISSUE;
                        mem_addr_d  = sel_addr;
                        mem_we_d    = sel_we;
                        mem_wdata_d = store_byte(d_wdata, sel_size, 2'd0);
                    end
                end
            end

            S_ISSUE: begin
                // read data for byte cnt-1 arrives while byte cnt is issued
                if (!we_q && (cnt_q != 2'd0)) begin
                    acc_d = acc_full;
                end
                if (cnt_q == last_idx(size_q)) begin
                    if (we_q) begin
                        state_d = S_DONE;
                        if (port_q == PORT_D) begin
                            d_done_d  = 1'b1;
                            d_rdata_d = 32'd0;
                        end else begin
                            i_done_d  = 1'b1;
                            i_rdata_d = 32'd0;
                        end
                    end else begin
                        state_d = S_CAPT;
                    end
                end else begin
                    cnt_d       = cnt_nxt;
                    mem_addr_d  = addr_q + ADDR_W'(cnt_nxt);
                    mem_we_d    = we_q;
                    mem_wdata_d = store_byte(wdata_q, size_q, cnt_nxt);
                end
            end

            S_CAPT: begin
                acc_d   = acc_full;
                state_d = S_DONE;
                if (port_q == PORT_D) begin
                    d_done_d  = 1'b1;
                    d_rdata_d = extend(acc_full, size_q, signed_q);
                end else begin
                    i_done_d  = 1'b1;
                    i_rdata_d = acc_full;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 2'd0;
            last_grant_q <= PORT_I;
            port_q       <= PORT_I;
            addr_q       <= '0;
            size_q       <= 2'b00;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            wdata_q      <= 32'd0;
            acc_q        <= 32'd0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 8'd0;
            i_rdata_q    <= 32'd0;
            i_done_q     <= 1'b0;
            i_err_q      <= 1'b0;
            d_rdata_q    <= 32'd0;
            d_done_q     <= 1'b0;
            d_err_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            we_q         <= we_d;
            signed_q     <= signed_d;
            wdata_q      <= wdata_d;
            acc_q        <= acc_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            i_done_q     <= i_done_d;
            i_err_q      <= i_err_d;
            d_rdata_q    <= d_rdata_d;
            d_done_q     <= d_done_d;
            d_err_q      <= d_err_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign i_done    = i_done_q;
    assign i_err     = i_err_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;
    assign d_err     = d_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Byte RAM model plus a reference memory image; expected port results are
//   queued when a request is driven and compared when its done pulse appears.
module tb_mem_port_arbiter;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [31:0]   i_rdata;
    logic          i_done, i_err;
    logic          d_req, d_we, d_signed;
    logic [1:0]    d_size;
    logic [AW-1:0] d_addr;
    logic [31:0]   d_wdata, d_rdata;
    logic          d_done, d_err;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata, mem_rdata;
    logic          busy;

    mem_port_arbiter #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    logic [7:0] ram     [0:1023];
    logic [7:0] ref_mem [0:1023];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int n_chk  = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int overlap = 0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) we_cnt++;
        if (i_done === 1'b1 && d_done === 1'b1) overlap++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t d_sb[$];
    exp_t i_sb[$];

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic is_err(input logic [1:0] size, input logic [AW-1:0] a);
        if (size == 2'b11) return 1'b1;
        if (size == 2'b01) return a[0];
        if (size == 2'b10) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [AW-1:0] a, input logic [1:0] size, input logic sgn);
        logic [31:0] v;
        int n;
        n = nbytes(size);
        v = 32'd0;
        for (int k = 0; k < n; k++) v = (v << 8) | 32'(ref_mem[AW'(a + AW'(k))]);
        if (n == 1 && sgn && v[7])  v = v | 32'hFFFF_FF00;
        if (n == 2 && sgn && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    // uncontended D-port access; lat is the expected req-to-done distance
    task automatic run_d(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                         input logic [AW-1:0] a, input logic [31:0] wd, input int lat);
        exp_t e;
        int n;
        int nb;
        e.err   = is_err(size, a);
        e.lat   = lat;
        e.rdata = (e.err || we) ? 32'd0 : model_load(a, size, sgn);
        if (we && !e.err) begin
            nb = nbytes(size);
            for (int k = 0; k < nb; k++)
                ref_mem[AW'(a + AW'(k))] = 8'(wd >> (8 * (nb - 1 - k)));
        end
        d_sb.push_back(e);
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_size = size; d_signed = sgn; d_addr = a; d_wdata = wd;
        n = 0;
        do begin
            @(posedge clk); n++; @(negedge clk);
            if (i_done === 1'b1) check_val({tag, "_stray_i_done"}, 32'(i_done), 32'd0);
        end while (d_done !== 1'b1 && n < 20);
        d_req = 1'b0;
        check_val({tag, "_done"}, 32'(d_done), 32'd1);
        e = d_sb.pop_front();
        check_val({tag, "_lat"}, n, e.lat);
        check_val({tag, "_err"}, 32'(d_err), 32'(e.err));
        if (!we || e.err) check_val({tag, "_rdata"}, d_rdata, e.rdata);
    endtask

    task automatic run_i(input string tag, input logic [AW-1:0] a, input int lat);
        exp_t e;
        int n;
        e.err   = is_err(2'b10, a);
        e.lat   = lat;
        e.rdata = e.err ? 32'd0 : model_load(a, 2'b10, 1'b0);
        i_sb.push_back(e);
        @(negedge clk);
        i_req = 1'b1; i_addr = a;
        n = 0;
        do begin
            @(posedge clk); n++; @(negedge clk);
        end while (i_done !== 1'b1 && n < 20);
        i_req = 1'b0;
        check_val({tag, "_done"}, 32'(i_done), 32'd1);
        e = i_sb.pop_front();
        check_val({tag, "_lat"}, n, e.lat);
        check_val({tag, "_err"}, 32'(i_err), 32'(e.err));
        check_val({tag, "_rdata"}, i_rdata, e.rdata);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [1:0] order_q[$];
        logic [1:0] ord;
        int d_left, i_left, done_cnt, cyc, we0;

        for (int k = 0; k < 1024; k++) begin
            ram[k]     = (k >= 1020) ? 8'h00 : 8'(k * 7 + 3);
            ref_mem[k] = ram[k];
        end
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_signed = 1'b0; d_addr = '0; d_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check_val("rst_busy",   32'(busy), 32'd0);
        check_val("rst_done",   {30'd0, i_done, d_done}, 32'd0);
        check_val("rst_err",    {30'd0, i_err, d_err}, 32'd0);
        check_val("rst_mem",    {21'd0, mem_we, mem_addr}, 32'd0);
        check_val("rst_d_rdata", d_rdata, 32'd0);
        check_val("rst_i_rdata", i_rdata, 32'd0);

        // both ports held: D wins the first conflict, then strict alternation
        order_q = '{2'b01, 2'b10, 2'b01, 2'b10};
        e.err = 1'b0; e.lat = -1;
        e.rdata = model_load(10'h020, 2'b10, 1'b0); d_sb.push_back(e);
        e.rdata = model_load(10'h040, 2'b10, 1'b0); i_sb.push_back(e);
        d_left = 1; i_left = 1; done_cnt = 0; cyc = 0;
        d_we = 1'b0; d_size = 2'b10; d_signed = 1'b0; d_addr = 10'h020;
        i_addr = 10'h040;
        d_req = 1'b1; i_req = 1'b1;
        while (done_cnt < 4 && cyc < 200) begin
            @(posedge clk); cyc++; @(negedge clk);
            if (d_done === 1'b1 || i_done === 1'b1) begin
                ord = (order_q.size() > 0) ? order_q.pop_front() : 2'b00;
                check_val("arb_order", {30'd0, i_done, d_done}, 32'(ord));
                done_cnt++;
            end
            if (d_done === 1'b1) begin
                e = d_sb.pop_front();
                check_val("arb_d_rdata", d_rdata, e.rdata);
                if (d_left > 0) begin d_left--; d_sb.push_back(e); end
                else d_req = 1'b0;
            end
            if (i_done === 1'b1) begin
                e = i_sb.pop_front();
                check_val("arb_i_rdata", i_rdata, e.rdata);
                if (i_left > 0) begin i_left--; i_sb.push_back(e); end
                else i_req = 1'b0;
            end
        end
        d_req = 1'b0; i_req = 1'b0;
        check_val("arb_done_count", done_cnt, 4);

        we0 = we_cnt;
        run_d("st_word", 1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 5);
        check_val("st_word_we_cycles", we_cnt - we0, 4);
        check_val("st_word_ram", {ram[16], ram[17], ram[18], ram[19]}, 32'hDEADBEEF);
        run_d("ld_word", 1'b0, 2'b10, 1'b0, 10'h010, 32'd0, 6);
        check_val("ld_word_value", d_rdata, 32'hDEADBEEF);
        run_i("fetch", 10'h010, 6);

        run_d("st_byte", 1'b1, 2'b00, 1'b0, 10'h013, 32'h0000_0080, 2);
        run_d("ld_byte_s", 1'b0, 2'b00, 1'b1, 10'h013, 32'd0, 3);
        check_val("ld_byte_s_value", d_rdata, 32'hFFFFFF80);
        run_d("ld_byte_u", 1'b0, 2'b00, 1'b0, 10'h013, 32'd0, 3);
        check_val("ld_byte_u_value", d_rdata, 32'h00000080);
        run_d("st_half", 1'b1, 2'b01, 1'b0, 10'h012, 32'h0000_8001, 3);
        run_d("ld_half_s", 1'b0, 2'b01, 1'b1, 10'h012, 32'd0, 4);
        check_val("ld_half_s_value", d_rdata, 32'hFFFF8001);

        we0 = we_cnt;
        run_d("mis_ld_word", 1'b0, 2'b10, 1'b0, 10'h006, 32'd0, 1);
        run_d("mis_st_half", 1'b1, 2'b01, 1'b0, 10'h003, 32'h0000_5A5A, 1);
        run_d("bad_size", 1'b0, 2'b11, 1'b0, 10'h008, 32'd0, 1);
        check_val("mis_no_we", we_cnt - we0, 0);
        check_val("mis_ram_unchanged", {ram[3], ram[4]}, {ref_mem[3], ref_mem[4]});
        run_i("fetch_mis", 10'h002, 1);

        run_d("ld_top0", 1'b0, 2'b10, 1'b0, 10'h3FC, 32'd0, 6);
        check_val("ld_top0_value", d_rdata, 32'h00000000);
        run_d("st_half_top", 1'b1, 2'b01, 1'b0, 10'h3FE, 32'h0000_1234, 3);
        check_val("st_half_top_ram", {ram[1022], ram[1023]}, 32'h1234);
        run_d("ld_top1", 1'b0, 2'b10, 1'b0, 10'h3FC, 32'd0, 6);
        run_d("st_word_top", 1'b1, 2'b10, 1'b0, 10'h3FC, 32'hCAFEF00D, 5);
        run_d("ld_top2", 1'b0, 2'b10, 1'b0, 10'h3FC, 32'd0, 6);
        check_val("ld_top2_value", d_rdata, 32'hCAFEF00D);

        // reset sampled on the edge that would advance the store to byte 2
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_signed = 1'b0;
        d_addr = 10'h030; d_wdata = 32'h11223344;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_val("abort_pre_addr", 32'(mem_addr), 32'h031);
        check_val("abort_pre_we",   32'(mem_we), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; d_req = 1'b0;
        check_val("abort_busy", 32'(busy), 32'd0);
        check_val("abort_done", 32'(d_done), 32'd0);
        check_val("abort_we",   32'(mem_we), 32'd0);
        check_val("abort_ram", {ram[48], ram[49], ram[50], ram[51]},
                  {8'h11, 8'h22, ref_mem[50], ref_mem[51]});
        ref_mem[48] = 8'h11;
        ref_mem[49] = 8'h22;
        run_d("after_abort", 1'b0, 2'b10, 1'b0, 10'h030, 32'd0, 6);

        check_val("no_done_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
